onehot_pulse_decoder: RTL

ONEHOT_PULSE_DECODER -- requirements
Module: onehot_pulse_decoder

---
 rtl/onehot_pulse_decoder.sv | 57 +++++
 1 files changed

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: decodes an accepted 2-bit index into a one-hot output held for HOLD enabled cycles
module onehot_pulse_decoder #(
    parameter int HOLD = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] in_sel,
    output logic       in_ready,
    input  logic       en,
    output logic [3:0] y,
    output logic       y_valid,
    output logic       done
);
    localparam int H = HOLD < 1 ? 1 : (HOLD > 15 ? 15 : HOLD);
    localparam logic [3:0] LOAD = 4'(H - 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [1:0] sel;
    // a new request can only be taken while idle
    always_comb in_ready = state == IDLE;
    // accept, hold the one-hot pattern for H enabled cycles, pulse done, then one gap cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            sel     <= 2'd0;
            y       <= 4'b0000;
            y_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    sel     <= in_sel;
                    cnt     <= LOAD;
                    y       <= 4'b0001 << in_sel;
                    y_valid <= 1'b1;
                    state   <= ACTIVE;
                end
                ACTIVE: if (en) begin
                    if (cnt == 4'd0) begin
                        y       <= 4'b0000;
                        y_valid <= 1'b0;
                        done    <= 1'b1;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt - 4'd1;
                        y   <= 4'b0001 << sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
